// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcode/func encodings, issue FSM states, ID/EX payload.
package cpu_defs;
   localparam int LINK_REG = 31;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;

   typedef enum logic {ISSUE = 1'b0, STALL = 1'b1} state_t;

   typedef struct packed {
      logic [31:0] first;
      logic [31:0] second;
      logic [5:0]  opcode;
      logic [5:0]  func;
      logic [4:0]  sa;
      logic [4:0]  dest;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic [31:0] store_data;
   } ex_op_t;

   // {reads rs, reads rt} for load-use detection
   function automatic logic [1:0] src_use(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_BEQ, OP_BNE, OP_SW:                         return 2'b11;
         OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW:     return 2'b10;
         default:                                                 return 2'b00;
      endcase
   endfunction
endpackage

// File: rtl/decode_issue_stage_if.sv
// Fetch, writeback, flush and ID/EX signals of the decode/issue stage.
interface decode_issue_stage_if;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_ready;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_first_val;
   logic [31:0] ex_second_val;
   logic [5:0]  ex_opcode;
   logic [5:0]  ex_func;
   logic [4:0]  ex_sa;
   logic [4:0]  ex_dest;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [31:0] ex_store_data;

   modport master (
      output if_valid, if_instr, if_pc, wb_en, wb_addr, wb_data, flush, ex_ready,
      input  if_ready, ex_valid, ex_first_val, ex_second_val, ex_opcode, ex_func,
             ex_sa, ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data
   );
   modport slave (
      input  if_valid, if_instr, if_pc, wb_en, wb_addr, wb_data, flush, ex_ready,
      output if_ready, ex_valid, ex_first_val, ex_second_val, ex_opcode, ex_func,
             ex_sa, ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data
   );
endinterface

// File: rtl/decode_issue_stage_reg_file.sv
// Two-read one-write register file; r0 reads zero, same-cycle write bypasses to reads.
module reg_file #(
   parameter  int NREGS = 32,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wb_en,
   input  logic [AW-1:0] wb_addr,
   input  logic [31:0]   wb_data,
   input  logic [AW-1:0] ra_addr,
   input  logic [AW-1:0] rb_addr,
   output logic [31:0]   ra_data,
   output logic [31:0]   rb_data
);
   logic [NREGS-1:0][31:0] regs;

   always_ff @(posedge clk) begin
      if (!rst_n)
         regs <= '0;
      else if (wb_en && wb_addr != '0)
         regs[wb_addr] <= wb_data;
   end

   always_comb begin
      ra_data = regs[ra_addr];
      if (ra_addr == '0)
         ra_data = '0;
      else if (wb_en && wb_addr == ra_addr)
         ra_data = wb_data;
      rb_data = regs[rb_addr];
      if (rb_addr == '0)
         rb_data = '0;
      else if (wb_en && wb_addr == rb_addr)
         rb_data = wb_data;
   end
endmodule

// File: rtl/decode_issue_stage.sv
// MIPS decode/issue stage: register read, operand select, load-use stall, ID/EX register.
module decode_issue_stage #(
   parameter int NREGS    = 32,
   parameter int LINK_REG = cpu_defs::LINK_REG
) (
   input logic                 clk,
   input logic                 rst_n,
   decode_issue_stage_if.slave bus
);
   import cpu_defs::*;

   logic [5:0]  op, func;
   logic [4:0]  rs, rt, rd, sa;
   logic [15:0] imm;
   logic [31:0] rs_val, rt_val;
   logic [1:0]  src;
   logic        hazard, if_ready, ex_valid;
   state_t      state, state_nxt;
   ex_op_t      dec, ex_q;

   assign op   = bus.if_instr[31:26];
   assign rs   = bus.if_instr[25:21];
   assign rt   = bus.if_instr[20:16];
   assign rd   = bus.if_instr[15:11];
   assign sa   = bus.if_instr[10:6];
   assign func = bus.if_instr[5:0];
   assign imm  = bus.if_instr[15:0];

   reg_file #(.NREGS(NREGS)) u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wb_en   (bus.wb_en),
      .wb_addr (bus.wb_addr),
      .wb_data (bus.wb_data),
      .ra_addr (rs),
      .rb_addr (rt),
      .ra_data (rs_val),
      .rb_data (rt_val)
   );

   assign src    = src_use(op);
   assign hazard = ex_valid && ex_q.mem_read && ex_q.dest != 5'd0 &&
                   ((src[1] && ex_q.dest == rs) || (src[0] && ex_q.dest == rt));

   always_comb begin
      dec            = '0;
      dec.opcode     = op;
      dec.func       = func;
      dec.sa         = sa;
      dec.first      = rs_val;
      dec.second     = rt_val;
      dec.store_data = rt_val;
      case (op)
         OP_RTYPE: begin
            dec.dest      = rd;
            dec.reg_write = (func != FN_JR);
         end
         OP_ADDI, OP_ADDIU: begin
            dec.second    = {{16{imm[15]}}, imm};
            dec.dest      = rt;
            dec.reg_write = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            dec.second    = {16'h0, imm};
            dec.dest      = rt;
            dec.reg_write = 1'b1;
         end
         OP_LW: begin
            dec.second    = {{16{imm[15]}}, imm};
            dec.dest      = rt;
            dec.reg_write = 1'b1;
            dec.mem_read  = 1'b1;
         end
         OP_SW: begin
            dec.second    = {{16{imm[15]}}, imm};
            dec.mem_write = 1'b1;
         end
         OP_JAL: begin
            dec.first     = bus.if_pc + 32'd8;
            dec.second    = '0;
            dec.dest      = 5'(LINK_REG);
            dec.reg_write = 1'b1;
         end
         default: ;
      endcase
   end

   // A hazard whose load drains this same edge needs no STALL visit: the
   // bubble is issued directly and the consumer is accepted next cycle.
   always_comb begin
      state_nxt = state;
      if_ready  = 1'b0;
      case (state)
         ISSUE: begin
            if_ready = rst_n && (!ex_valid || bus.ex_ready) && !hazard && !bus.flush;
            if (!bus.flush && hazard && bus.if_valid && !bus.ex_ready)
               state_nxt = STALL;
         end
         STALL: begin
            if (bus.flush || bus.ex_ready)
               state_nxt = ISSUE;
         end
         default: state_nxt = ISSUE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ISSUE;
         ex_valid <= 1'b0;
         ex_q     <= '0;
      end else begin
         state <= state_nxt;
         if (bus.flush)
            ex_valid <= 1'b0;
         else if (bus.if_valid && if_ready) begin
            ex_valid <= 1'b1;
            ex_q     <= dec;
         end else if (bus.ex_ready)
            ex_valid <= 1'b0;
      end
   end

   assign bus.if_ready      = if_ready;
   assign bus.ex_valid      = ex_valid;
   assign bus.ex_first_val  = ex_q.first;
   assign bus.ex_second_val = ex_q.second;
   assign bus.ex_opcode     = ex_q.opcode;
   assign bus.ex_func       = ex_q.func;
   assign bus.ex_sa         = ex_q.sa;
   assign bus.ex_dest       = ex_q.dest;
   assign bus.ex_reg_write  = ex_q.reg_write;
   assign bus.ex_mem_read   = ex_q.mem_read;
   assign bus.ex_mem_write  = ex_q.mem_write;
   assign bus.ex_store_data = ex_q.store_data;
endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_decode_issue_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [31:0] mregs [32];

   typedef struct {
      logic [31:0] first, second, store;
      logic [5:0]  op, fn;
      logic [4:0]  sa, dest;
      logic        rw, mr, mw, use_rs, use_rt;
      logic        chk_first, chk_second, chk_dest, chk_store;
   } exp_t;

   always #5 clk = ~clk;

   decode_issue_stage_if bus();
   decode_issue_stage #(.NREGS(32), .LINK_REG(31)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] rv(input logic [4:0] r, input logic wbe,
                                      input logic [4:0] wba, input logic [31:0] wbd);
      if (r == 0) return 32'd0;
      if (wbe && wba == r) return wbd;
      return mregs[r];
   endfunction

   // What the stage should issue for one instruction, from the ISA rules.
   function automatic exp_t model_issue(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic wbe, input logic [4:0] wba, input logic [31:0] wbd);
      exp_t e;
      logic [4:0] rs, rt, rd;
      logic [31:0] imm_u, imm_s;
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      imm_u = 32'(ins[15:0]);
      imm_s = (ins[15:0] >= 16'h8000) ? imm_u + 32'hFFFF0000 : imm_u;
      e = '{default: '0};
      e.op = ins[31:26]; e.fn = ins[5:0]; e.sa = ins[10:6];
      case (int'(ins[31:26]))
         0: begin
            e.first = rv(rs, wbe, wba, wbd); e.second = rv(rt, wbe, wba, wbd);
            e.dest = rd; e.rw = (ins[5:0] != 6'd8);
            e.chk_first = 1; e.chk_second = 1; e.chk_dest = 1; e.use_rs = 1; e.use_rt = 1;
         end
         8, 9, 12, 13, 14, 35: begin
            e.first = rv(rs, wbe, wba, wbd);
            e.second = (ins[31:26] >= 6'd12 && ins[31:26] <= 6'd14) ? imm_u : imm_s;
            e.dest = rt; e.rw = 1; e.mr = (ins[31:26] == 6'd35);
            e.chk_first = 1; e.chk_second = 1; e.chk_dest = 1; e.use_rs = 1;
         end
         43: begin
            e.first = rv(rs, wbe, wba, wbd); e.second = imm_s; e.store = rv(rt, wbe, wba, wbd);
            e.mw = 1; e.chk_first = 1; e.chk_second = 1; e.chk_store = 1; e.use_rs = 1; e.use_rt = 1;
         end
         4, 5: begin
            e.first = rv(rs, wbe, wba, wbd); e.second = rv(rt, wbe, wba, wbd);
            e.chk_first = 1; e.chk_second = 1; e.use_rs = 1; e.use_rt = 1;
         end
         3: begin
            e.first = pc + 32'd8; e.dest = 5'd31; e.rw = 1;
            e.chk_first = 1; e.chk_dest = 1;
         end
         default: ;
      endcase
      return e;
   endfunction

   task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
      bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
      @(negedge clk);
      bus.wb_en = 1'b0;
      if (a != 0) mregs[a] = d;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; bus.if_valid = 1'b1; bus.if_instr = 32'h00A60820; bus.ex_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (bus.if_ready !== 1'b0) begin failures++; $display("FAIL reset_if_ready: got %b want 0", bus.if_ready); end
      checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid: got %b want 0", bus.ex_valid); end
      checks++;
      if ({bus.ex_first_val, bus.ex_second_val, bus.ex_store_data, bus.ex_opcode, bus.ex_func, bus.ex_sa,
           bus.ex_dest, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} !== '0) begin
         failures++; $display("FAIL reset_ex_fields: got first=%h second=%h dest=%0d want all zero",
                              bus.ex_first_val, bus.ex_second_val, bus.ex_dest);
      end
      rst_n = 1'b1; bus.if_valid = 1'b0;
      foreach (mregs[i]) mregs[i] = 32'd0;
      @(negedge clk); #1;
      checks++; if (bus.if_ready !== 1'b1) begin failures++; $display("FAIL idle_if_ready: got %b want 1", bus.if_ready); end
   endtask

   task automatic test_add;
      rf_write(5, 32'd7); rf_write(6, 32'd3);
      bus.if_valid = 1'b1; bus.if_instr = 32'h00A60820; bus.if_pc = 32'h40; bus.ex_ready = 1'b1;
      #1;
      checks++; if (bus.if_ready !== 1'b1) begin failures++; $display("FAIL add_accept: got %b want 1", bus.if_ready); end
      @(negedge clk);
      bus.if_valid = 1'b0;
      checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL add_valid: got %b want 1", bus.ex_valid); end
      checks++; if (bus.ex_first_val !== 32'd7 || bus.ex_second_val !== 32'd3)
         begin failures++; $display("FAIL add_operands: got %0d,%0d want 7,3", bus.ex_first_val, bus.ex_second_val); end
      checks++; if (bus.ex_dest !== 5'd1 || bus.ex_reg_write !== 1'b1)
         begin failures++; $display("FAIL add_dest: got %0d/%b want 1/1", bus.ex_dest, bus.ex_reg_write); end
      @(negedge clk);
      checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL add_drain: got %b want 0", bus.ex_valid); end
   endtask

   task automatic test_imm;
      bus.if_valid = 1'b1; bus.if_instr = 32'h34028000; bus.ex_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.ex_second_val !== 32'h00008000 || bus.ex_dest !== 5'd2)
         begin failures++; $display("FAIL ori_zext: got %h/%0d want 00008000/2", bus.ex_second_val, bus.ex_dest); end
      bus.if_instr = 32'h20028000;
      @(negedge clk);
      bus.if_valid = 1'b0;
      checks++; if (bus.ex_valid !== 1'b1 || bus.ex_second_val !== 32'hFFFF8000 || bus.ex_opcode !== 6'h08)
         begin failures++; $display("FAIL addi_sext: got v=%b %h op=%h want v=1 ffff8000 op=08",
                                    bus.ex_valid, bus.ex_second_val, bus.ex_opcode); end
      @(negedge clk);
   endtask

   task automatic test_load_use;
      logic r1, r2, bub;
      bus.if_valid = 1'b1; bus.if_instr = 32'h8C240000; bus.ex_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.ex_mem_read !== 1'b1 || bus.ex_dest !== 5'd4)
         begin failures++; $display("FAIL lw_issue: got mr=%b dest=%0d want 1/4", bus.ex_mem_read, bus.ex_dest); end
      bus.if_instr = 32'h00841820;
      #1 r1 = bus.if_ready;
      @(negedge clk);
      bub = bus.ex_valid;
      #1 r2 = bus.if_ready;
      @(negedge clk);
      bus.if_valid = 1'b0;
      checks++; if (r1 !== 1'b0 || r2 !== 1'b1) begin failures++; $display("FAIL lu_ready_seq: got %b%b want 01", r1, r2); end
      checks++; if (bub !== 1'b0) begin failures++; $display("FAIL lu_bubble: got %b want 0", bub); end
      checks++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd3 || bus.ex_first_val !== mregs[4])
         begin failures++; $display("FAIL lu_add_issue: got v=%b dest=%0d want 1/3", bus.ex_valid, bus.ex_dest); end
      // same hazard while EX is back-pressured
      bus.if_valid = 1'b1; bus.if_instr = 32'h8C240000;
      @(negedge clk);
      bus.if_instr = 32'h00841820; bus.ex_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (bus.if_ready !== 1'b0 || bus.ex_mem_read !== 1'b1)
            begin failures++; $display("FAIL stall_hold: got rdy=%b mr=%b want 0/1", bus.if_ready, bus.ex_mem_read); end
         @(negedge clk);
      end
      bus.ex_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL stall_bubble: got %b want 0", bus.ex_valid); end
      @(negedge clk);
      bus.if_valid = 1'b0;
      checks++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd3)
         begin failures++; $display("FAIL stall_resume: got v=%b dest=%0d want 1/3", bus.ex_valid, bus.ex_dest); end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      bus.if_valid = 1'b1; bus.if_instr = 32'h00A60820; bus.ex_ready = 1'b1;
      @(negedge clk);
      bus.ex_ready = 1'b0; bus.if_instr = 32'h00A64022;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (bus.if_ready !== 1'b0) begin failures++; $display("FAIL bp_if_ready: got %b want 0", bus.if_ready); end
         @(negedge clk);
         checks++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd1 || bus.ex_first_val !== 32'd7 || bus.ex_func !== 6'h20)
            begin failures++; $display("FAIL bp_stable: got v=%b dest=%0d first=%0d want 1/1/7", bus.ex_valid, bus.ex_dest, bus.ex_first_val); end
      end
      bus.ex_ready = 1'b1;
      #1;
      checks++; if (bus.if_ready !== 1'b1) begin failures++; $display("FAIL bp_resume_ready: got %b want 1", bus.if_ready); end
      @(negedge clk);
      bus.if_valid = 1'b0;
      checks++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd8 || bus.ex_func !== 6'h22)
         begin failures++; $display("FAIL bp_next: got v=%b dest=%0d fn=%h want 1/8/22", bus.ex_valid, bus.ex_dest, bus.ex_func); end
      @(negedge clk);
   endtask

   task automatic test_flush;
      bus.if_valid = 1'b1; bus.if_instr = 32'h00A60820; bus.ex_ready = 1'b1;
      @(negedge clk);
      bus.flush = 1'b1; bus.ex_ready = 1'b0; bus.if_instr = 32'h00A64022;
      #1;
      checks++; if (bus.if_ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b want 0", bus.if_ready); end
      @(negedge clk);
      bus.flush = 1'b0; bus.if_valid = 1'b0;
      checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL flush_kill: got %b want 0", bus.ex_valid); end
      @(negedge clk);
      checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL flush_drop: got %b want 0", bus.ex_valid); end
      bus.ex_ready = 1'b1;
   endtask

   task automatic test_r0_jal;
      rf_write(0, 32'hDEADBEEF);
      bus.if_valid = 1'b1; bus.if_instr = 32'h00003820; bus.ex_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.ex_first_val !== 32'd0 || bus.ex_second_val !== 32'd0)
         begin failures++; $display("FAIL r0_read: got %h/%h want 0/0", bus.ex_first_val, bus.ex_second_val); end
      bus.if_instr = 32'h0C000040; bus.if_pc = 32'h100;
      @(negedge clk);
      checks++; if (bus.ex_first_val !== 32'h108 || bus.ex_dest !== 5'd31 || bus.ex_reg_write !== 1'b1)
         begin failures++; $display("FAIL jal_link: got %h/%0d/%b want 108/31/1", bus.ex_first_val, bus.ex_dest, bus.ex_reg_write); end
      bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h12345678; bus.if_instr = 32'h01205020;
      @(negedge clk);
      bus.wb_en = 1'b0; bus.if_valid = 1'b0; mregs[9] = 32'h12345678;
      checks++; if (bus.ex_first_val !== 32'h12345678)
         begin failures++; $display("FAIL write_through: got %h want 12345678", bus.ex_first_val); end
      @(negedge clk);
   endtask

   task automatic test_random;
      exp_t m, e;
      logic m_valid, held, acc, hz, exp_rdy;
      logic [31:0] ins;
      logic [5:0] ops [16];
      logic [5:0] fns [8];
      ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
              6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h23, 6'h2B, 6'h0F, 6'h3F};
      fns = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h08, 6'h00, 6'h2A};
      bus.if_valid = 1'b0; bus.flush = 1'b0; bus.ex_ready = 1'b1; bus.wb_en = 1'b0;
      @(negedge clk);
      m = '{default: '0}; m_valid = 1'b0; held = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         checks++; if (bus.ex_valid !== m_valid)
            begin failures++; $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, bus.ex_valid, m_valid); end
         if (m_valid) begin
            checks++;
            if ({bus.ex_opcode, bus.ex_func, bus.ex_sa, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} !==
                {m.op, m.fn, m.sa, m.rw, m.mr, m.mw})
               begin failures++; $display("FAIL rnd_ctl[%0d]: got op=%h rw%b mr%b mw%b want op=%h rw%b mr%b mw%b", cyc,
                  bus.ex_opcode, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, m.op, m.rw, m.mr, m.mw); end
            if (m.chk_first) begin checks++; if (bus.ex_first_val !== m.first)
               begin failures++; $display("FAIL rnd_first[%0d]: got %h want %h", cyc, bus.ex_first_val, m.first); end end
            if (m.chk_second) begin checks++; if (bus.ex_second_val !== m.second)
               begin failures++; $display("FAIL rnd_second[%0d]: got %h want %h", cyc, bus.ex_second_val, m.second); end end
            if (m.chk_dest) begin checks++; if (bus.ex_dest !== m.dest)
               begin failures++; $display("FAIL rnd_dest[%0d]: got %0d want %0d", cyc, bus.ex_dest, m.dest); end end
            if (m.chk_store) begin checks++; if (bus.ex_store_data !== m.store)
               begin failures++; $display("FAIL rnd_store[%0d]: got %h want %h", cyc, bus.ex_store_data, m.store); end end
         end
         if (!held) begin
            ins = {ops[$urandom_range(15)], 5'($urandom_range(7)), 5'($urandom_range(7)), 16'($urandom)};
            if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(7)];
            bus.if_instr = ins;
            bus.if_pc = {$urandom, 2'b00} >> 2 << 2;
            bus.if_valid = ($urandom_range(3) != 0);
         end
         bus.ex_ready = ($urandom_range(3) != 0);
         bus.flush    = ($urandom_range(15) == 0);
         bus.wb_en    = ($urandom_range(2) == 0);
         bus.wb_addr  = 5'($urandom_range(7));
         bus.wb_data  = $urandom;
         e  = model_issue(bus.if_instr, bus.if_pc, bus.wb_en, bus.wb_addr, bus.wb_data);
         hz = m_valid && m.mr && m.dest != 0 &&
              ((e.use_rs && m.dest == bus.if_instr[25:21]) || (e.use_rt && m.dest == bus.if_instr[20:16]));
         exp_rdy = (!m_valid || bus.ex_ready) && !hz && !bus.flush;
         #1;
         checks++; if (bus.if_ready !== exp_rdy)
            begin failures++; $display("FAIL rnd_if_ready[%0d]: got %b want %b", cyc, bus.if_ready, exp_rdy); end
         acc = bus.if_valid && exp_rdy;
         if (bus.flush) m_valid = 1'b0;
         else if (acc) begin m = e; m_valid = 1'b1; end
         else if (bus.ex_ready) m_valid = 1'b0;
         held = bus.if_valid && !acc && !bus.flush;
         if (bus.wb_en && bus.wb_addr != 0) mregs[bus.wb_addr] = bus.wb_data;
         @(negedge clk);
      end
      bus.if_valid = 1'b0; bus.flush = 1'b0; bus.wb_en = 1'b0; bus.ex_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_stall;
      rf_write(5, 32'd7);
      bus.if_valid = 1'b1; bus.if_instr = 32'h8C240000; bus.ex_ready = 1'b1;
      @(negedge clk);
      bus.if_instr = 32'h00841820; bus.ex_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b0; bus.wb_en = 1'b1; bus.wb_addr = 5'd12; bus.wb_data = 32'h55;
      @(negedge clk);
      rst_n = 1'b1; bus.wb_en = 1'b0; bus.if_valid = 1'b0; bus.ex_ready = 1'b1;
      checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL rst_stall_valid: got %b want 0", bus.ex_valid); end
      bus.if_valid = 1'b1; bus.if_instr = 32'h00AC5820;
      #1;
      checks++; if (bus.if_ready !== 1'b1) begin failures++; $display("FAIL rst_stall_ready: got %b want 1", bus.if_ready); end
      @(negedge clk);
      bus.if_valid = 1'b0;
      checks++; if (bus.ex_valid !== 1'b1 || bus.ex_first_val !== 32'd0 || bus.ex_second_val !== 32'd0)
         begin failures++; $display("FAIL rst_regs_clear: got v=%b %h/%h want 1 0/0", bus.ex_valid, bus.ex_first_val, bus.ex_second_val); end
      @(negedge clk);
   endtask

   initial begin
      bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0; bus.wb_en = 1'b0;
      bus.wb_addr = '0; bus.wb_data = '0; bus.flush = 1'b0; bus.ex_ready = 1'b1;
      foreach (mregs[i]) mregs[i] = 32'd0;
      @(negedge clk);
      test_reset;
      test_add;
      test_imm;
      test_load_use;
      test_backpressure;
      test_flush;
      test_r0_jal;
      test_random;
      test_reset_mid_stall;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
